// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between N requesters. Requester 0 (VGA pixel path) can have
// fixed priority, and a starvation counter guarantees the others make progress. Read latency is 2 cycles.
module sprite_rom_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned FIXED0   = 1,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          req,
  input  logic [N*ADDR_W-1:0]   addr,
  output logic [N-1:0]          gnt,
  output logic [DATA_W-1:0]     rdata,
  output logic [N-1:0]          rvalid,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [DATA_W-1:0]     rom_q
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1_v_q, s2_v_q;
  logic [IDW-1:0]    s1_id_q, s2_id_q;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [DATA_W-1:0] rdata_q;

  logic              others_pend;
  logic              starve;
  logic              fixed_win;
  logic              rr_found;
  logic [IDW-1:0]    rr_id;
  logic [IDW-1:0]    cand;
  logic              win_v;
  logic              win_rr;
  logic [IDW-1:0]    win_id;

  assign others_pend = |req[N-1:1];
  assign starve      = (cnt_q == CW'(MAX_WAIT)) && others_pend;
  assign fixed_win   = (FIXED0 != 0) && req[0] && !starve;

  // Round-robin search from the pointer; requester 0 is masked while a starvation override is active.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    cand     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IDW'((32'(ptr_q) + off) % N);
      if (!rr_found && req[cand] && !(starve && (cand == '0))) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
  end

  always_comb begin
    win_v  = 1'b0;
    win_rr = 1'b0;
    win_id = '0;
    if (fixed_win) begin
      win_v = 1'b1;
    end else if (rr_found) begin
      win_v  = 1'b1;
      win_rr = 1'b1;
      win_id = rr_id;
    end
  end

  always_comb begin
    gnt = '0;
    if (win_v && reset_n) begin
      gnt[win_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_v && win_rr) begin
      ptr_d = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((win_v && (win_id != '0)) || !others_pend) begin
      cnt_d = '0;
    end else if (fixed_win && (cnt_q != CW'(MAX_WAIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    rom_address_d = rom_address_q;
    if (win_v) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (win_id == IDW'(i)) begin
          rom_address_d = addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      cnt_q         <= '0;
      s1_v_q        <= 1'b0;
      s1_id_q       <= '0;
      s2_v_q        <= 1'b0;
      s2_id_q       <= '0;
      rom_address_q <= '0;
      rdata_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      s1_v_q        <= win_v;
      s1_id_q       <= win_id;
      s2_v_q        <= s1_v_q;
      s2_id_q       <= s1_id_q;
      rom_address_q <= rom_address_d;
      if (s2_v_q) begin
        rdata_q <= rom_q;
      end
    end
  end

  // rom_q is the ROM's own output register; it is presented during the valid cycle and held afterwards.
  always_comb begin
    rvalid = '0;
    rdata  = rdata_q;
    if (s2_v_q) begin
      rvalid[s2_id_q] = 1'b1;
      rdata           = rom_q;
    end
  end

  assign rom_address = rom_address_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: one instance with fixed priority for requester 0,
// one in pure round-robin mode, each attached to its own registered ROM model.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_a, req_b, gnt_a, gnt_b, rv_a, rv_b;
  logic [N*AW-1:0] addr_a, addr_b;
  logic [DW-1:0]   rd_a, rd_b, romq_a, romq_b;
  logic [AW-1:0]   ra_a, ra_b;

  sprite_rom_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED0(1), .MAX_WAIT(7)) dut_a (
    .vga_clk(clk), .reset_n(rst_n), .req(req_a), .addr(addr_a), .gnt(gnt_a),
    .rdata(rd_a), .rvalid(rv_a), .rom_address(ra_a), .rom_q(romq_a));

  sprite_rom_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED0(0), .MAX_WAIT(7)) dut_b (
    .vga_clk(clk), .reset_n(rst_n), .req(req_b), .addr(addr_b), .gnt(gnt_b),
    .rdata(rd_b), .rvalid(rv_b), .rom_address(ra_b), .rom_q(romq_b));

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]} ^ 4'h5;
  endfunction

  always @(posedge clk) romq_a <= rom_fn(ra_a);
  always @(posedge clk) romq_b <= rom_fn(ra_b);

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("rvalid_a", 32'(rv_a), 32'(1) << qa[0].id);
      chk("rdata_a", 32'(rd_a), 32'(qa[0].data));
      void'(qa.pop_front());
    end else if (rv_a != '0) begin
      chk("unexpected_rvalid_a", 32'(rv_a), 32'(0));
    end
  end

  always @(posedge clk) begin
    #1;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("rvalid_b", 32'(rv_b), 32'(1) << qb[0].id);
      chk("rdata_b", 32'(rd_b), 32'(qb[0].data));
      void'(qb.pop_front());
    end else if (rv_b != '0) begin
      chk("unexpected_rvalid_b", 32'(rv_b), 32'(0));
    end
  end

  // Drives one cycle of requests, checks the same-cycle grant and queues the expected read return.
  task automatic step(input bit use_b, input logic [N-1:0] r, input logic [N*AW-1:0] av,
                      input int exp_id, input string name);
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    exp_t          e;
    @(posedge clk);
    #1;
    if (use_b) begin
      req_b = r; addr_b = av;
    end else begin
      req_a = r; addr_a = av;
    end
    #2;
    eg = (exp_id < 0) ? '0 : (N'(1) << exp_id);
    chk(name, use_b ? 32'(gnt_b) : 32'(gnt_a), 32'(eg));
    if (exp_id >= 0) begin
      ea     = av[exp_id*AW +: AW];
      e.due  = cyc + 2;
      e.id   = exp_id;
      e.data = rom_fn(ea);
      if (use_b) qb.push_back(e);
      else       qa.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*AW-1:0] av;
    rst_n  = 1'b0;
    req_a  = '0; req_b = '0;
    addr_a = '0; addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt_a), 32'(0));
    chk("reset_rvalid", 32'(rv_a), 32'(0));
    chk("reset_rdata", 32'(rd_a), 32'(0));
    chk("reset_rom_address", 32'(ra_a), 32'(0));
    rst_n = 1'b1;

    // Single read from requester 2.
    av = '0;
    av[2*AW +: AW] = 10'h123;
    step(0, 4'b0100, av, 2, "single_gnt");
    step(0, 4'b0000, av, -1, "single_idle");
    chk("single_rom_address", 32'(ra_a), 32'h123);
    repeat (2) step(0, 4'b0000, av, -1, "single_idle");

    // Pure round-robin with every requester pending.
    av = {10'h073, 10'h062, 10'h051, 10'h040};
    for (int i = 0; i < 8; i++) step(1, 4'b1111, av, i % 4, "rr_gnt");
    repeat (3) step(1, 4'b0000, av, -1, "rr_idle");

    // Fixed priority with starvation override: 7 grants to 0, then one to 1.
    av = {10'h000, 10'h000, 10'h31f, 10'h200};
    for (int i = 0; i < 16; i++) step(0, 4'b0011, av, (i % 8 == 7) ? 1 : 0, "starve_gnt");
    step(0, 4'b0000, av, -1, "starve_idle");

    // Back-to-back reads from requester 3.
    for (int i = 0; i < 4; i++) begin
      av = '0;
      av[3*AW +: AW] = AW'(i);
      step(0, 4'b1000, av, 3, "b2b_gnt");
    end
    repeat (4) step(0, 4'b0000, av, -1, "b2b_idle");
    chk("rdata_hold", 32'(rd_a), 32'(rom_fn(10'd3)));

    // Requester 2 drops before being granted; counter must return to 0.
    av = {10'h000, 10'h155, 10'h2cc, 10'h0aa};
    repeat (2) step(0, 4'b0101, av, 0, "drop_gnt");
    step(0, 4'b0001, av, 0, "drop_gnt");
    for (int i = 0; i < 8; i++) step(0, 4'b0011, av, (i == 7) ? 1 : 0, "post_drop_gnt");

    // Reset asserted with reads in flight.
    repeat (2) step(0, 4'b0001, av, 0, "pre_reset_gnt");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("midreset_gnt", 32'(gnt_a), 32'(0));
    chk("midreset_rvalid", 32'(rv_a), 32'(0));
    chk("midreset_rdata", 32'(rd_a), 32'(0));
    chk("midreset_rom_address", 32'(ra_a), 32'(0));
    req_a = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0000, av, -1, "post_reset_gnt");
      chk("post_reset_rvalid", 32'(rv_a), 32'(0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", 32'(qa.size() + qb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (1-cycle registered-address read) between N requesters: the display pixel fetch, tank sprites, bullet sprites.
- Requester 0 is the VGA pixel path and may be given fixed priority. A starvation counter guarantees the other requesters still make progress.
- Sits between the per-object draw logic and the ROM/palette pair. It returns palette indices tagged to the requester that issued the read.

Parameters:
- N, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM word width (palette index)
- FIXED0, 1, 1 = requester 0 wins whenever it requests (subject to starvation override); 0 = pure round-robin
- MAX_WAIT, 7, consecutive requester-0 grants tolerated while others are pending before override

Ports:
- vga_clk  input  1  sole clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  N  per-requester read request, held until granted
- addr  input  N*ADDR_W  request addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  output  N  one-hot grant, combinational in the request cycle
- rdata  output  DATA_W  read data, registered
- rvalid  output  N  one-hot, rdata belongs to the flagged requester
- rom_address  output  ADDR_W  registered ROM address
- rom_q  input  DATA_W  ROM output, valid one cycle after rom_address

Behaviour:
- Reset (reset_n low, async): gnt=0, rvalid=0, rdata=0, rom_address=0, rr pointer=0, starvation counter=0, pipeline valid bits=0.
  - In-flight reads are discarded; no rvalid is produced for them after reset is released.
- Grant (cycle k):
  - gnt is one-hot or zero, derived combinationally from req, the pointer, the counter and FIXED0.
  - At most one grant per cycle; throughput is 1 read/cycle.
- Selection order:
  - (a) If counter==MAX_WAIT and any of req[N-1:1] is high: round-robin among 1..N-1 from the pointer; requester 0 is not granted.
  - (b) Else if FIXED0 and req[0] is high: grant 0.
  - (c) Else: round-robin over all requesters, starting at the pointer.
- Pointer update: on a round-robin grant to w, ptr <= (w+1) mod N. A fixed-priority grant to 0 leaves ptr unchanged.
- Counter rules:
  - Increments (saturating at MAX_WAIT) on a cycle where 0 is granted via (b) while any req[N-1:1] is high.
  - Clears on any grant to a requester other than 0, or on a cycle where no other requester is pending.
- Pipeline:
  - At the end of grant cycle k: rom_address <= addr[w]; s1_id <= w; s1_v <= 1. With no grant, s1_v <= 0 and rom_address holds its value.
  - Cycle k+1: the ROM samples rom_address.
  - Cycle k+2: rvalid[s1_id_d]=1 and rdata=rom_q, registered from the k+1 stage. Fixed latency of 2 cycles from gnt to rvalid.
- Handshake:
  - A requester must hold req and addr stable until it sees gnt.
  - Dropping req before a grant is legal: nothing is issued.
  - req held after gnt counts as a new request, so back-to-back grants to the same requester are allowed.
- With no req, outputs idle: gnt=0, rvalid=0 two cycles later, rdata holds its last value.
- Simultaneous events: a new grant and an rvalid for an earlier grant in the same cycle are independent and both occur.
- Width rule: the internal id is $clog2(N) bits. Pointer wrap uses modulo N, not a power of two.

Test Plan:
- Reset: reset_n low mid-stream with grants in flight -> gnt=0, rvalid=0, rdata=0, rom_address=0 immediately. No rvalid in the 3 cycles after release with req=0.
- Single read: req=4'b0100, addr[2]=10'h123 at cycle 0 -> gnt=4'b0100 at cycle 0; rom_address=10'h123 at cycle 1; rvalid=4'b0100 with rdata=ROM[0x123] at cycle 2.
- Round-robin, FIXED0=0: req=4'b1111 held 8 cycles -> grants in order 0,1,2,3,0,1,2,3, with rvalid following each 2 cycles later.
- Fixed priority plus starvation, FIXED0=1, MAX_WAIT=7: req=4'b0011 held -> requester 0 granted 7 consecutive cycles, requester 1 granted on the 8th, then 0 resumes.
- Back-to-back: req[3] held 4 cycles with addresses 0,1,2,3 -> 4 consecutive rvalid[3] returning ROM[0..3] in order.
- Drop before grant: FIXED0=1, req[0] high continuously, req[2] pulsed for 2 cycles -> no grant to 2 and no rvalid[2]; counter returns to 0.
